// File: rtl/tick_timer_if.sv
// Bundles the divided-clock inputs, countdown control and timer status of tick_timer.
// The master side drives the divided clocks and controls; the slave side is the timer.
interface tick_timer_if #(
    parameter int N_DIV = 3,
    parameter int CNT_W = 8
);
    logic [N_DIV-1:0] div_in;
    logic             start;
    logic             pause;
    logic [CNT_W-1:0] load_val;
    logic [N_DIV-1:0] tick;
    logic [CNT_W-1:0] count;
    logic             running;
    logic             done;
    logic             expired;

    modport master (
        output div_in, start, pause, load_val,
        input  tick, count, running, done, expired
    );

    modport slave (
        input  div_in, start, pause, load_val,
        output tick, count, running, done, expired
    );
endinterface

// File: rtl/tick_timer.sv
// Re-times divided square-wave clocks into single-cycle tick enables and runs a
// loadable countdown that decrements on the selected tick.
module tick_timer #(
    parameter int N_DIV     = 3,
    parameter int CNT_W     = 8,
    parameter int TIMER_SEL = 0
) (
    input  logic         clk,
    input  logic         rst,
    tick_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    logic [N_DIV-1:0] s1_q, s2_q, s3_q, tick_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             running_q, expired_q;

    // Synchronizer chain and rising-edge detect; chain resets high so a div_in
    // already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= {N_DIV{1'b1}};
            s2_q   <= {N_DIV{1'b1}};
            s3_q   <= {N_DIV{1'b1}};
            tick_q <= {N_DIV{1'b0}};
        end else begin
            s1_q   <= bus.div_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            tick_q <= s2_q & ~s3_q;
        end
    end

    // Countdown next-state: start overrides pause, pause overrides tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (bus.start) begin
            if (bus.load_val != {CNT_W{1'b0}}) begin
                count_d = bus.load_val;
                state_d = ST_RUN;
            end else begin
                count_d = {CNT_W{1'b0}};
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick_q[TIMER_SEL]) begin
                        if (count_q > CNT_W'(1)) begin
                            count_d = count_q - CNT_W'(1);
                        end else begin
                            count_d = {CNT_W{1'b0}};
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    count_d = {CNT_W{1'b0}};
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, count and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= {CNT_W{1'b0}};
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_DONE);
        end
    end

    assign bus.tick    = tick_q;
    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: an edge-timestamp/countdown model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_tick_timer;
    localparam int N_DIV     = 3;
    localparam int CNT_W     = 8;
    localparam int TIMER_SEL = 0;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tick_timer_if #(.N_DIV(N_DIV), .CNT_W(CNT_W)) bus ();
    tick_timer #(.N_DIV(N_DIV), .CNT_W(CNT_W), .TIMER_SEL(TIMER_SEL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a rising sample of div_in seen at edge j must show as a tick after edge j+2.
    int               cyc = 0;
    int               due [N_DIV];
    bit               prev_samp [N_DIV];
    logic [N_DIV-1:0] m_tick;
    int               m_mode;
    int               m_count;
    bit               m_done;

    always @(posedge clk) begin
        bit tsel;
        cyc++;
        if (rst) begin
            for (int i = 0; i < N_DIV; i++) begin
                due[i] = -1;
                prev_samp[i] = 1'b1;
            end
            m_tick  = '0;
            m_mode  = M_IDLE;
            m_count = 0;
            m_done  = 1'b0;
        end else begin
            tsel = m_tick[TIMER_SEL];
            for (int i = 0; i < N_DIV; i++) begin
                if (bus.div_in[i] && !prev_samp[i]) due[i] = cyc + 2;
                prev_samp[i] = bus.div_in[i];
                m_tick[i] = (due[i] == cyc);
            end
            m_done = 1'b0;
            if (bus.start) begin
                if (bus.load_val != 0) begin
                    m_count = bus.load_val;
                    m_mode  = M_RUN;
                end else begin
                    m_count = 0;
                    m_mode  = M_DONE;
                    m_done  = 1'b1;
                end
            end else if (m_mode == M_RUN) begin
                if (bus.pause) m_mode = M_PAUSED;
                else if (tsel) begin
                    m_count = (m_count > 1) ? m_count - 1 : 0;
                    if (m_count == 0) begin
                        m_mode = M_DONE;
                        m_done = 1'b1;
                    end
                end
            end else if (m_mode == M_PAUSED && !bus.pause) begin
                m_mode = M_RUN;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("tick",    32'(bus.tick),    32'(m_tick));
            check("count",   32'(bus.count),   32'(m_count));
            check("running", 32'(bus.running), 32'(m_mode == M_RUN));
            check("done",    32'(bus.done),    32'(m_done));
            check("expired", 32'(bus.expired), 32'(m_mode == M_DONE));
        end
    end

    // Pulse counters sample the pre-edge output values.
    int tick_cnt [N_DIV];
    int done_cnt = 0;
    initial for (int i = 0; i < N_DIV; i++) tick_cnt[i] = 0;
    always @(posedge clk) begin
        if (checking && !rst) begin
            for (int i = 0; i < N_DIV; i++) if (bus.tick[i] === 1'b1) tick_cnt[i]++;
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick0();
        bus.div_in[0] = 1'b0;
        step(4);
        bus.div_in[0] = 1'b1;
        step(5);
    endtask

    initial begin
        int lat;
        int base;
        rst          = 1'b1;
        bus.div_in   = 3'b111;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.load_val = 8'd0;
        step(2);
        checking = 1'b1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_flags", 32'({bus.running, bus.done, bus.expired}), 32'd0);
        step(1);
        rst = 1'b0;

        // 1: high inputs at reset release give no tick; one rising edge gives one tick
        step(20);
        check("t1_no_spurious", 32'(tick_cnt[0] + tick_cnt[1] + tick_cnt[2]), 32'd0);
        bus.div_in[0] = 1'b0;
        step(5);
        bus.div_in[0] = 1'b1;
        lat = 0;
        while (lat < 10 && bus.tick[0] !== 1'b1) begin
            step(1);
            lat++;
        end
        check("t1_latency_ok", 32'(lat >= 3 && lat <= 4), 32'd1);
        step(10);
        check("t1_one_tick", 32'(tick_cnt[0]), 32'd1);

        // 2: five rising edges of a 40-cycle square wave
        base = tick_cnt[1];
        for (int k = 0; k < 5; k++) begin
            bus.div_in[1] = 1'b0;
            step(20);
            bus.div_in[1] = 1'b1;
            step(20);
        end
        step(5);
        check("t2_five_ticks", 32'(tick_cnt[1] - base), 32'd5);
        check("t2_bit2_quiet", 32'(tick_cnt[2]), 32'd0);

        // 3: count 3 -> 0
        bus.load_val = 8'd3;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("t3_load", 32'(bus.count), 32'd3);
        check("t3_running", 32'(bus.running), 32'd1);
        base = done_cnt;
        tick0();
        check("t3_cnt2", 32'(bus.count), 32'd2);
        tick0();
        check("t3_cnt1", 32'(bus.count), 32'd1);
        tick0();
        check("t3_cnt0", 32'(bus.count), 32'd0);
        check("t3_done_once", 32'(done_cnt - base), 32'd1);
        check("t3_state", 32'({bus.running, bus.expired}), 32'b01);

        // 4: pause freezes the count
        bus.load_val = 8'd5;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        tick0();
        tick0();
        check("t4_cnt3", 32'(bus.count), 32'd3);
        bus.pause = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) tick0();
        check("t4_frozen", 32'(bus.count), 32'd3);
        check("t4_not_running", 32'(bus.running), 32'd0);
        bus.pause = 1'b0;
        step(2);
        check("t4_resumed", 32'(bus.running), 32'd1);
        base = done_cnt;
        for (int k = 0; k < 3; k++) tick0();
        check("t4_expired", 32'(bus.expired), 32'd1);
        check("t4_done_once", 32'(done_cnt - base), 32'd1);

        // 5: zero load goes straight to DONE; reload from DONE
        bus.load_val = 8'd0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("t5_done_pulse", 32'({bus.done, bus.expired}), 32'b11);
        check("t5_cnt0", 32'(bus.count), 32'd0);
        step(1);
        check("t5_done_drop", 32'({bus.done, bus.expired}), 32'b01);
        bus.load_val = 8'd9;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("t5_reload", 32'(bus.count), 32'd9);
        check("t5_run", 32'({bus.running, bus.expired}), 32'b10);

        // 6: reset mid-count forgets the count
        bus.load_val = 8'd4;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        tick0();
        check("t6_cnt3", 32'(bus.count), 32'd3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_count", 32'(bus.count), 32'd0);
        check("t6_rst_flags", 32'({bus.running, bus.done, bus.expired, bus.tick}), 32'd0);
        tick0();
        tick0();
        check("t6_idle_count", 32'(bus.count), 32'd0);
        check("t6_idle_run", 32'(bus.running), 32'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
